branch_predictor: RTL

Fetch-stage dynamic branch predictor for the RV32I pipeline, closing the loop with the EX-stage branch unit. Each cycle it gives a taken/not-taken prediction and a target for the PC in Fetch, using a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB). When a conditional branch resolves in Execute, the block trains both tables from the resolved outcome and flags a misprediction to the hazard unit.

---
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor.sv | 102 ++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - Fetch/Execute signal bundle between the pipeline and branch_predictor
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  // Fetch-side prediction
  logic [XLEN-1:0] PCF;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  // Execute-side resolution and training
  logic            updateE;
  logic [XLEN-1:0] PCE;
  logic            branchTakenE;
  logic [XLEN-1:0] PCTargetE;
  logic            PredTakenE;
  logic [XLEN-1:0] PredTargetE;
  logic            mispredictE;
  // Performance counters
  logic [31:0]     branchCount;
  logic [31:0]     mispredictCount;

  modport master (
    output PCF, updateE, PCE, branchTakenE, PCTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, mispredictE, branchCount, mispredictCount
  );

  modport slave (
    input  PCF, updateE, PCE, branchTakenE, PCTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, mispredictE, branchCount, mispredictCount
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit counter + BTB branch predictor; optional perf counters via BP_PERF_CNT_EN
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  logic [1:0]       r_counter [ENTRIES];
  logic             r_valid   [ENTRIES];
  logic [TAG_W-1:0] r_tag     [ENTRIES];
  logic [XLEN-1:0]  r_target  [ENTRIES];

  logic [IDX_BITS-1:0] w_idx_f;
  logic [IDX_BITS-1:0] w_idx_e;
  logic [TAG_W-1:0]    w_tag_f;
  logic [TAG_W-1:0]    w_tag_e;
  logic                w_hit_f;
  logic [1:0]          w_ctr_next;
  logic                w_mispredict;
  logic                w_unused;

  assign w_idx_f = bp.PCF[IDX_BITS+1:2];
  assign w_tag_f = bp.PCF[XLEN-1:IDX_BITS+2];
  assign w_idx_e = bp.PCE[IDX_BITS+1:2];
  assign w_tag_e = bp.PCE[XLEN-1:IDX_BITS+2];

  // Instruction-aligned PCs: the byte-offset bits carry no information
  assign w_unused = ^{bp.PCF[1:0], bp.PCE[1:0]};

  // Prediction reads the registered tables only, so a same-cycle update is not bypassed
  assign w_hit_f        = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign bp.PredTakenF  = w_hit_f && r_counter[w_idx_f][1];
  assign bp.PredTargetF = w_hit_f ? r_target[w_idx_f] : '0;

  // Redirect when the direction was wrong, or a taken prediction pointed to the wrong target
  assign w_mispredict = bp.updateE &&
                        ((bp.branchTakenE != bp.PredTakenE) ||
                         (bp.branchTakenE && bp.PredTakenE && (bp.PredTargetE != bp.PCTargetE)));
  assign bp.mispredictE = w_mispredict;

  // Saturating counter step for the resolving branch
  always_comb begin
    w_ctr_next = r_counter[w_idx_e];
    if (bp.branchTakenE) begin
      if (r_counter[w_idx_e] != 2'b11) w_ctr_next = r_counter[w_idx_e] + 2'b01;
    end else begin
      if (r_counter[w_idx_e] != 2'b00) w_ctr_next = r_counter[w_idx_e] - 2'b01;
    end
  end

  // Counter, valid and target tables: reset wins over a pending training write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_counter[i] <= 2'b01;
        r_valid[i]   <= 1'b0;
        r_target[i]  <= '0;
      end
    end else if (bp.updateE) begin
      r_counter[w_idx_e] <= w_ctr_next;
      if (bp.branchTakenE) begin
        r_valid[w_idx_e]  <= 1'b1;
        r_target[w_idx_e] <= bp.PCTargetE;
      end
    end
  end

  // Tag table: contents are irrelevant while the entry is invalid, so no reset is needed
  always_ff @(posedge clk) begin
    if (!reset && bp.updateE && bp.branchTakenE) begin
      r_tag[w_idx_e] <= w_tag_e;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Free-running resolved-branch and misprediction counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (bp.updateE)   r_branch_count     <= r_branch_count + 32'd1;
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign bp.branchCount     = r_branch_count;
  assign bp.mispredictCount = r_mispredict_count;
`else
  assign bp.branchCount     = '0;
  assign bp.mispredictCount = '0;
`endif

endmodule
